demux_stream: RTL

Parametrised N-way stream demultiplexer with a valid/ready handshake, a one-entry registered slot per output channel, and a unicast/broadcast mode. It succeeds the combinational 2-way demux in the datapath. It sits between a single producer and N independent consumers and absorbs consumer back-pressure per channel. It also flags and drops out-of-range selects, and counts accepted words.

---
 rtl/demux_stream_pkg.sv | 15 +
 rtl/demux_stream_out_slot.sv | 48 ++++
 rtl/demux_stream.sv | 103 ++++++++++
 3 files changed

// File: rtl/demux_stream_pkg.sv
// Shared types and constants for the demux_stream stream demultiplexer.
// Imported by the top level and the per-channel slot.
package demux_stream_pkg;

  localparam logic SLOT_EMPTY = 1'b0;
  localparam logic SLOT_FULL  = 1'b1;

  // How the word currently offered by the producer is routed.
  typedef enum logic [1:0] {
    MODE_UNICAST = 2'd0,
    MODE_BCAST   = 2'd1,
    MODE_DROP    = 2'd2
  } mode_e;

endpackage

// File: rtl/demux_stream_out_slot.sv
// One-entry registered output slot: a data register plus its valid bit.
// A load wins over a drain, so a slot can drain and refill on the same edge.
module out_slot
  import demux_stream_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         drain,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  output logic         free
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = load_data;
      valid_d = SLOT_FULL;
    end else if (drain) begin
      valid_d = SLOT_EMPTY;
    end
  end

  // NOTE: state registers use non-blocking assignments only; blocking here would race other flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= SLOT_EMPTY;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign free      = !valid_q || drain;

endmodule

// File: rtl/demux_stream.sv
// N-way valid/ready stream demultiplexer with per-channel slots, broadcast mode,
// a sticky out-of-range select flag and a wrapping accepted-word counter.
module demux_stream
  import demux_stream_pkg::*;
#(
  parameter int W  = 16,
  parameter int N  = 4,
  parameter int SW = $clog2(N),
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W-1:0]    in_data,
  input  logic [SW-1:0]   in_select,
  input  logic            in_bcast,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [N*W-1:0]  out_data,
  output logic [N-1:0]    out_valid,
  input  logic [N-1:0]    out_ready,
  output logic            err_sel,
  output logic [CW-1:0]   acc_count
);

  localparam logic [SW:0] N_LIMIT = (SW+1)'(N);

  mode_e         mode;
  logic [N-1:0]  slot_free;
  logic [N-1:0]  slot_load;
  logic          accept;
  logic          err_q, err_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mode = MODE_DROP;
    if (in_bcast) begin
      mode = MODE_BCAST;
    end else if ({1'b0, in_select} < N_LIMIT) begin
      mode = MODE_UNICAST;
    end
  end

  // in_ready depends only on slot state, select and mode, never on in_valid.
  always_comb begin
    in_ready = 1'b0;
    case (mode)
      MODE_BCAST:   in_ready = &slot_free;
      MODE_UNICAST: in_ready = slot_free[in_select];
      default:      in_ready = 1'b1;
    endcase
    if (rst) begin
      in_ready = 1'b0;
    end
  end

  always_comb begin
    accept    = in_valid && in_ready;
    slot_load = '0;
    for (int i = 0; i < N; i++) begin
      slot_load[i] = accept && ((mode == MODE_BCAST) ||
                                (mode == MODE_UNICAST && in_select == SW'(i)));
    end
  end

  always_comb begin
    err_d   = err_q;
    count_d = count_q;
    if (accept) begin
      if (mode == MODE_DROP) begin
        err_d = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign err_sel   = err_q;
  assign acc_count = count_q;

  for (genvar i = 0; i < N; i++) begin : g_slot
    out_slot #(.W(W)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (slot_load[i]),
      .load_data (in_data),
      .drain     (out_ready[i]),
      .out_data  (out_data[i*W +: W]),
      .out_valid (out_valid[i]),
      .free      (slot_free[i])
    );
  end

endmodule
